occupancy_counter: RTL and testbench

- Downstream consumer of the car-park entry/exit FSM's `entered` and `exited` pulses.
- Maintains the current car count, bounded by a capacity.
- Classifies occupancy into a 4-state status machine (EMPTY/AVAILABLE/NEAR_FULL/FULL) and flags sticky overflow/underflow errors.
- Outputs drive board LEDs and the display stage.

---
 rtl/occupancy_counter_pkg.sv | 14 +
 rtl/occupancy_counter_if.sv | 38 +++
 rtl/occupancy_counter_rise_detect.sv | 30 +++
 rtl/occupancy_counter.sv | 141 ++++++++++++++
 tb/tb_occupancy_counter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/occupancy_counter_pkg.sv
// Shared types and default constants for the car-park occupancy counter.
package carpark_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_AVAIL = 2'b01,
        OCC_NEAR  = 2'b10,
        OCC_FULL  = 2'b11
    } occ_status_t;

    localparam int unsigned OCC_DEFAULT_CAPACITY    = 15;
    localparam int unsigned OCC_DEFAULT_NEAR_MARGIN = 2;

endpackage

// File: rtl/occupancy_counter_if.sv
// Event inputs and occupancy outputs of the occupancy counter.
// Optional BCD digit outputs are present when OCC_BCD_EN is defined.
interface occupancy_counter_if #(
    parameter int unsigned CNT_W = 4
);
    logic             entered;
    logic             exited;
    logic             clear;
    logic [CNT_W-1:0] count;
    logic [1:0]       status;
    logic             full;
    logic             empty;
    logic             err_overflow;
    logic             err_underflow;
`ifdef OCC_BCD_EN
    logic [3:0]       bcd_tens;
    logic [3:0]       bcd_ones;
`endif

    // Producer of events / consumer of occupancy
    modport master (
        output entered, exited, clear,
        input  count, status, full, empty, err_overflow, err_underflow
`ifdef OCC_BCD_EN
        , input bcd_tens, bcd_ones
`endif
    );

    // The occupancy counter itself
    modport slave (
        input  entered, exited, clear,
        output count, status, full, empty, err_overflow, err_underflow
`ifdef OCC_BCD_EN
        , output bcd_tens, bcd_ones
`endif
    );

endinterface

// File: rtl/occupancy_counter_rise_detect.sv
// Single-bit rising-edge detector with a registered one-cycle event pulse.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);
    logic prev_q, prev_d;
    logic rise_q, rise_d;

    // Next-state: remember the input and flag a 0->1 transition
    always_comb begin
        prev_d = in;
        rise_d = in & ~prev_q;
    end

    // Edge history and event pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/occupancy_counter.sv
// Car-park occupancy counter: bounded count, 4-state status, sticky errors.
// Optional macro OCC_BCD_EN adds registered decimal digits of the count.
module occupancy_counter
    import carpark_pkg::*;
#(
    parameter int unsigned CAPACITY    = OCC_DEFAULT_CAPACITY,
    parameter int unsigned NEAR_MARGIN = OCC_DEFAULT_NEAR_MARGIN
) (
    input  logic                clk,
    input  logic                reset,
    occupancy_counter_if.slave  bus
);
    localparam int unsigned      CNT_W   = $clog2(CAPACITY + 1);
    localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] NEAR_LO = CNT_W'(CAPACITY - NEAR_MARGIN);

    logic inc_ev;
    logic dec_ev;

    // Clear is registered alongside the event pulses so that a clear and an
    // edge sampled on the same clock land together and the clear wins.
    logic clear_q, clear_d;

    logic [CNT_W-1:0] count_q, count_d;
    occ_status_t      status_q, status_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    rise_detect u_rise_entered (
        .clk  (clk),
        .rst  (reset),
        .in   (bus.entered),
        .rise (inc_ev)
    );

    rise_detect u_rise_exited (
        .clk  (clk),
        .rst  (reset),
        .in   (bus.exited),
        .rise (dec_ev)
    );

    // Next count, error flags and status classification of the next count
    always_comb begin
        clear_d = bus.clear;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (clear_q) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (inc_ev && dec_ev) begin
            count_d = count_q;
        end else if (inc_ev) begin
            if (count_q == CAP_C) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec_ev) begin
            if (count_q == '0) begin
                unf_d = 1'b1;
            end else begin
                count_d = count_q - CNT_W'(1);
            end
        end

        if (count_d == '0) begin
            status_d = OCC_EMPTY;
        end else if (count_d == CAP_C) begin
            status_d = OCC_FULL;
        end else if (count_d >= NEAR_LO) begin
            status_d = OCC_NEAR;
        end else begin
            status_d = OCC_AVAIL;
        end

        full_d  = (status_d == OCC_FULL);
        empty_d = (status_d == OCC_EMPTY);
    end

    // Occupancy state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_q  <= 1'b0;
            count_q  <= '0;
            status_q <= OCC_EMPTY;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            clear_q  <= clear_d;
            count_q  <= count_d;
            status_q <= status_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.count         = count_q;
    assign bus.status        = status_q;
    assign bus.full          = full_q;
    assign bus.empty         = empty_q;
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = unf_q;

`ifdef OCC_BCD_EN
    logic [7:0] cnt8;
    logic [3:0] bcd_tens_q, bcd_tens_d;
    logic [3:0] bcd_ones_q, bcd_ones_d;

    // Decimal digits of the registered count (capacity limited to 99)
    always_comb begin
        cnt8       = 8'(count_q);
        bcd_tens_d = 4'(cnt8 / 8'd10);
        bcd_ones_d = 4'(cnt8 % 8'd10);
    end

    // BCD digit registers, one cycle behind count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_tens_q <= '0;
            bcd_ones_q <= '0;
        end else begin
            bcd_tens_q <= bcd_tens_d;
            bcd_ones_q <= bcd_ones_d;
        end
    end

    assign bus.bcd_tens = bcd_tens_q;
    assign bus.bcd_ones = bcd_ones_q;
`endif

endmodule

// File: tb/tb_occupancy_counter.sv
// Directed self-checking bench for occupancy_counter (CAPACITY=15, NEAR_MARGIN=2).
module tb_occupancy_counter;

    logic clk;
    logic reset;
    int   passed;
    int   failed;
    int   total;

    occupancy_counter_if #(.CNT_W(4)) bus ();

    occupancy_counter #(
        .CAPACITY    (15),
        .NEAR_MARGIN (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle entered pulse; returns once the count has been updated
    task automatic pulse_in();
        bus.entered = 1'b1;
        tick();
        bus.entered = 1'b0;
        tick();
    endtask

    task automatic pulse_out();
        bus.exited = 1'b1;
        tick();
        bus.exited = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick();
    endtask

    task automatic check_outputs(input string tag, input int cnt, input int st,
                                 input int ovf, input int unf);
        check({tag, ".count"}, 32'(bus.count), 32'(cnt));
        check({tag, ".status"}, 32'(bus.status), 32'(st));
        check({tag, ".full"}, 32'(bus.full), 32'(st == 3));
        check({tag, ".empty"}, 32'(bus.empty), 32'(st == 0));
        check({tag, ".ovf"}, 32'(bus.err_overflow), 32'(ovf));
        check({tag, ".unf"}, 32'(bus.err_underflow), 32'(unf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        passed = 0;
        failed = 0;
        total  = 0;
        bus.entered = 1'b0;
        bus.exited  = 1'b0;
        bus.clear   = 1'b0;
        reset = 1'b1;
        #23;
        check_outputs("reset", 0, 0, 0, 0);
        reset = 1'b0;
        tick();

        // Three single-cycle pulses, each visible one cycle after sampling
        for (int i = 0; i < 3; i++) begin
            bus.entered = 1'b1;
            tick();
            bus.entered = 1'b0;
            check("pulse.before", 32'(bus.count), 32'(i));
            tick();
            check("pulse.after", 32'(bus.count), 32'(i + 1));
        end
        check_outputs("three", 3, 1, 0, 0);

        // Asynchronous reset mid-cycle clears everything immediately
        #3;
        reset = 1'b1;
        #1;
        check_outputs("midreset", 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        tick();

        // Held-high entered counts once
        bus.entered = 1'b1;
        repeat (10) tick();
        bus.entered = 1'b0;
        tick();
        tick();
        check_outputs("held", 1, 1, 0, 0);

        // Fill to capacity, watching status boundaries
        for (int c = 2; c <= 15; c++) begin
            pulse_in();
            if (c == 12) check("st12", 32'(bus.status), 32'd1);
            if (c == 13) check("st13", 32'(bus.status), 32'd2);
            if (c == 14) check("st14", 32'(bus.status), 32'd2);
        end
        check_outputs("full", 15, 3, 0, 0);

        // Simultaneous edges at capacity: no change, no error
        bus.entered = 1'b1;
        bus.exited  = 1'b1;
        tick();
        bus.entered = 1'b0;
        bus.exited  = 1'b0;
        tick();
        check_outputs("both@15", 15, 3, 0, 0);

        // 16th entry overflows
        pulse_in();
        check_outputs("ovf", 15, 3, 1, 0);

        // Counting continues with sticky error
        pulse_out();
        check_outputs("dec14", 14, 2, 1, 0);

        do_clear();
        check_outputs("clr1", 0, 0, 0, 0);

        // Exit while empty underflows
        pulse_out();
        check_outputs("unf", 0, 0, 0, 1);

        // Simultaneous edges at zero
        bus.entered = 1'b1;
        bus.exited  = 1'b1;
        tick();
        bus.entered = 1'b0;
        bus.exited  = 1'b0;
        tick();
        check_outputs("both@0", 0, 0, 0, 1);

        do_clear();
        check_outputs("clr2", 0, 0, 0, 0);

        // Clear together with entered at count 5
        repeat (5) pulse_in();
        check_outputs("five", 5, 1, 0, 0);
        bus.clear   = 1'b1;
        bus.entered = 1'b1;
        tick();
        bus.clear   = 1'b0;
        bus.entered = 1'b0;
        tick();
        check_outputs("clr+in", 0, 0, 0, 0);
        tick();
        check("clr+in.late", 32'(bus.count), 32'd0);

        // Input already high when reset releases counts once
        #3;
        reset = 1'b1;
        bus.entered = 1'b1;
        #3;
        reset = 1'b0;
        tick();
        tick();
        check("highrel", 32'(bus.count), 32'd1);
        repeat (3) tick();
        bus.entered = 1'b0;
        check("highrel.once", 32'(bus.count), 32'd1);
        tick();

`ifdef OCC_BCD_EN
        for (int c = 2; c <= 12; c++) pulse_in();
        check("bcd.cnt", 32'(bus.count), 32'd12);
        check("bcd.tens.lag", 32'(bus.bcd_tens), 32'd1);
        check("bcd.ones.lag", 32'(bus.bcd_ones), 32'd1);
        tick();
        check("bcd.tens", 32'(bus.bcd_tens), 32'd1);
        check("bcd.ones", 32'(bus.bcd_ones), 32'd2);
        #3;
        reset = 1'b1;
        #1;
        check_outputs("bcdreset", 0, 0, 0, 0);
        check("bcd.tens.rst", 32'(bus.bcd_tens), 32'd0);
        check("bcd.ones.rst", 32'(bus.bcd_ones), 32'd0);
        reset = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
